// File: rtl/dma_pkg.sv
// Shared definitions for the DMA block scheduler slice.
// Provides the default widths, the memory read/write encoding, the
// scheduler FSM state type and the memory word type.
package dma_pkg;

  localparam int unsigned DMA_ADDR_WIDTH = 16;
  localparam int unsigned DMA_DATA_WIDTH = 16;
  localparam int unsigned DMA_BLOCK_SIZE = 25;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_DRAIN,
    RESP
  } state_t;

  typedef logic [DMA_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/dma_block_scheduler_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector
//   en        : accept strobe; advances the priority pointer past the grant
//   grant     : one-hot grant, first set bit at or above the pointer (wrapping)
//   grant_id  : index of the granted requester
//   found     : at least one request is set
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               found
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/dma_block_scheduler.sv
// Shares a single-port memory between NUM_REQ requesters. Serves single-word
// writes and BLOCK_SIZE-word burst reads, packing read words into one wide
// block response.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/rw/addr/wdata       : per-requester request (flat slices)
//   req_ready                     : registered one-hot accept pulse
//   resp_valid/resp_id/resp_data  : block-read completion
//   busy                          : controller not idle
//   mem_en/rw/addr/wdata, rdata   : memory port (read data 1 cycle late)
module dma_block_scheduler
  import dma_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = DMA_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
  parameter  int unsigned BLOCK_SIZE = DMA_BLOCK_SIZE,
  parameter  int unsigned NUM_REQ    = 2,
  localparam int unsigned IW         = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             resp_valid,
  output logic [IW-1:0]                    resp_id,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_data,
  output logic                             busy,
  output logic                             mem_en,
  output logic                             mem_rw,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int unsigned     CW   = $clog2(BLOCK_SIZE + 1);
  localparam logic [CW-1:0]   LAST = CW'(BLOCK_SIZE - 1);

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [IW-1:0]          id_q;
  logic [DATA_WIDTH-1:0]  rd_buf [BLOCK_SIZE-1];

  logic [NUM_REQ-1:0]     grant;
  logic [IW-1:0]          grant_id;
  logic                   found;
  logic                   accept;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign accept = (state == IDLE) && found;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (accept),
    .grant    (grant),
    .grant_id (grant_id),
    .found    (found)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (found) state_next = req_rw[grant_id] ? RD_ISSUE : WRITE;
      WRITE:    state_next = IDLE;
      RD_ISSUE: if (cnt == LAST) state_next = RD_DRAIN;
      RD_DRAIN: state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= '0;
      req_ready <= '0;
      resp_data <= '0;
    end else begin
      req_ready <= accept ? grant : '0;
      if (accept) begin
        addr_q  <= addr_arr[grant_id];
        wdata_q <= wdata_arr[grant_id];
        id_q    <= grant_id;
        cnt     <= '0;
      end
      if (state == RD_ISSUE) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      // Words collect in rd_buf so resp_data stays stable until the next
      // block is complete; it is replaced in one step on the drain cycle.
      if (state == RD_DRAIN) begin
        for (int unsigned k = 0; k < BLOCK_SIZE - 1; k++) begin
          resp_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_buf[k];
        end
        resp_data[(BLOCK_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
      end
    end
  end

  // Read data lags the issue by one cycle, so issue slot n captures word n-1.
  always_ff @(posedge clk) begin
    if (state == RD_ISSUE && cnt != '0) begin
      rd_buf[cnt - 1'b1] <= mem_rdata;
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_rw     = MEM_WR;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    busy       = (state != IDLE);
    case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_rw   = MEM_RD;
        mem_addr = addr_q + ADDR_WIDTH'(cnt);
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_block_scheduler.sv
module tb_dma_block_scheduler;
  import dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BS = 25;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_rw, req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              resp_valid;
  logic [0:0]        resp_id;
  logic [BS*DW-1:0]  resp_data;
  logic              busy, mem_en, mem_rw;
  logic [AW-1:0]     mem_addr;
  word_t             mem_wdata;
  word_t             mem_rdata = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_count = 0;

  // Memory contents default to mem[i] = i until written.
  word_t mem [int];
  word_t ref_mem [int];

  dma_block_scheduler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_SIZE (BS),
    .NUM_REQ    (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resp_valid) resp_count <= resp_count + 1;
    if (mem_en) begin
      if (mem_rw) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : mem_addr;
      else        mem[int'(mem_addr)] = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [BS*DW-1:0] act, input logic [BS*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic word_t rd_ref(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a;
  endfunction

  function automatic logic [BS*DW-1:0] exp_block(input logic [15:0] base);
    logic [BS*DW-1:0] r;
    logic [15:0] a;
    r = '0;
    for (int k = 0; k < BS; k++) begin
      a = base + 16'(k);
      r[k*DW +: DW] = rd_ref(a);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit rw, input logic [15:0] a, input logic [15:0] d);
    req_valid[i]        = 1'b1;
    req_rw[i]           = rw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  typedef struct {
    int          rq;
    bit          rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  exp_ready;
    logic [15:0] exp_w0;
    logic [15:0] exp_w4;
    logic [15:0] exp_wl;
  } vec_t;

  typedef struct {
    int               id;
    int               due;
    logic [BS*DW-1:0] data;
  } exp_resp_t;

  vec_t tbl [6];

  initial begin
    vec_t        v;
    bit          got;
    int          t_ready;
    int          saved;
    int          nresp;
    int          exp_id;
    int          gq [$];
    int          gl [$];
    exp_resp_t   eq [$];
    exp_resp_t   e;
    int          ptr_m;
    int          g;
    int          grants;
    logic [NR-1:0] prev_valid;
    logic [15:0] ra;
    logic [15:0] rd;
    bit          rrw;

    tbl[0] = '{0, 1'b0, 16'h0010, 16'h0400, 2'b01, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1, 1'b1, 16'h0064, 16'h0000, 2'b10, 16'h0064, 16'h0068, 16'h007C};
    tbl[2] = '{0, 1'b1, 16'h000C, 16'h0000, 2'b01, 16'h000C, 16'h0400, 16'h0024};
    tbl[3] = '{1, 1'b1, 16'hFFF0, 16'h0000, 2'b10, 16'hFFF0, 16'hFFF4, 16'h0008};
    tbl[4] = '{1, 1'b0, 16'hFFFF, 16'hBEEF, 2'b10, 16'h0000, 16'h0000, 16'h0000};
    tbl[5] = '{0, 1'b1, 16'hFFFC, 16'h0000, 2'b01, 16'hFFFC, 16'h0000, 16'h0014};

    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    do_reset();

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle mem_en", mem_en, 0);
      chk("idle busy", busy, 0);
    end
    chk("idle outputs", {req_ready, resp_valid, resp_id, busy, mem_en, mem_rw, mem_addr, mem_wdata}, 0);
    chk_blk("idle resp_data", resp_data, '0);

    // isolated transactions from the table
    for (int n = 0; n < 6; n++) begin
      v = tbl[n];
      set_req(v.rq, v.rw, v.addr, v.wdata);
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        tick();
        if (req_ready != '0) got = 1;
      end
      t_ready = cyc;
      chk("vec req_ready", req_ready, v.exp_ready);
      req_valid = '0;
      if (!v.rw) begin
        chk("vec write port", {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b1, 1'b0, v.addr, v.wdata});
        ref_mem[int'(v.addr)] = v.wdata;
        tick();
        chk("vec write done", {busy, mem_en, req_ready}, 0);
      end else begin
        for (int k = 0; k < BS; k++) begin
          chk("vec issue", {mem_en, mem_rw, mem_addr}, {1'b1, 1'b1, v.addr + 16'(k)});
          tick();
        end
        chk("vec drain", {mem_en, resp_valid}, 0);
        tick();
        chk("vec resp_valid", resp_valid, 1);
        chk("vec resp latency", cyc - t_ready, 26);
        chk("vec resp_id", resp_id, v.rq);
        chk("vec word0", resp_data[0 +: DW], v.exp_w0);
        chk("vec word4", resp_data[4*DW +: DW], v.exp_w4);
        chk("vec word24", resp_data[24*DW +: DW], v.exp_wl);
        chk_blk("vec block", resp_data, exp_block(v.addr));
        tick();
        chk("vec back idle", {busy, resp_valid}, 0);
        chk_blk("vec data held", resp_data, exp_block(v.addr));
      end
    end

    // continuous contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    set_req(0, 1'b1, 16'h0100, 16'h0);
    set_req(1, 1'b1, 16'h0200, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    nresp = 0;
    for (int w = 0; w < 200 && nresp < 4; w++) begin
      tick();
      if (req_ready != '0) begin
        chk("cont onehot", $onehot(req_ready), 1);
        gl.push_back(req_ready[1] ? 1 : 0);
        gq.push_back(req_ready[1] ? 1 : 0);
      end
      if (resp_valid) begin
        exp_id = (gq.size() > 0) ? gq.pop_front() : -1;
        chk("cont resp_id", resp_id, 64'(exp_id));
        chk_blk("cont data", resp_data, exp_block(exp_id == 1 ? 16'h0200 : 16'h0100));
        nresp++;
      end
    end
    req_valid = '0;
    chk("cont resp count", nresp, 4);
    for (int i = 0; i < 4; i++) begin
      chk("cont order", (i < gl.size()) ? 64'(gl[i]) : '1, i % 2);
    end
    tick();
    tick();

    // reset during the 10th issue cycle aborts the read
    set_req(0, 1'b1, 16'h0300, 16'h0);
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      if (req_ready != '0) got = 1;
    end
    chk("abort ready", req_ready, 2'b01);
    req_valid = '0;
    repeat (9) tick();
    chk("abort 10th issue", {mem_en, mem_rw, mem_addr}, {1'b1, 1'b1, 16'h0309});
    rst = 1'b1;
    saved = resp_count;
    tick();
    chk("abort mem_en", mem_en, 0);
    chk("abort busy", busy, 0);
    chk_blk("abort resp_data", resp_data, '0);
    rst = 1'b0;
    repeat (40) tick();
    chk("abort no resp", resp_count, saved);
    set_req(0, 1'b1, 16'h0040, 16'h0);
    set_req(1, 1'b1, 16'h0080, 16'h0);
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      if (req_ready != '0) got = 1;
    end
    chk("abort priority", req_ready, 2'b01);
    req_valid = '0;
    got = 0;
    for (int w = 0; w < 40 && !got; w++) begin
      tick();
      if (resp_valid) got = 1;
    end
    chk("abort resume resp", resp_valid, 1);
    chk("abort resume id", resp_id, 0);
    chk_blk("abort resume data", resp_data, exp_block(16'h0040));
    tick();

    // randomized traffic against a round-robin reference model
    do_reset();
    ptr_m = 0;
    grants = 0;
    prev_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      if (req_ready != '0) begin
        if (prev_valid == '0) begin
          chk("rnd grant", req_ready, 0);
        end else begin
          g = prev_valid[ptr_m] ? ptr_m : (ptr_m + 1) % NR;
          chk("rnd grant", req_ready, 64'(1) << g);
          ptr_m = (g + 1) % NR;
          grants++;
          ra = req_addr[g*AW +: AW];
          rd = req_wdata[g*DW +: DW];
          if (!req_rw[g]) begin
            chk("rnd write", {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b1, 1'b0, ra, rd});
            ref_mem[int'(ra)] = rd;
          end else begin
            e.id = g;
            e.due = cyc + 26;
            e.data = exp_block(ra);
            eq.push_back(e);
          end
          req_valid[g] = 1'b0;
        end
      end
      if (resp_valid) begin
        if (eq.size() == 0) begin
          chk("rnd resp unexpected", resp_valid, 0);
        end else begin
          e = eq.pop_front();
          chk("rnd resp_id", resp_id, e.id);
          chk("rnd resp time", cyc, e.due);
          chk_blk("rnd resp data", resp_data, e.data);
        end
      end else if (eq.size() > 0 && cyc >= eq[0].due) begin
        chk("rnd resp missing", resp_valid, 1);
        void'(eq.pop_front());
      end
      if (c < 2700) begin
        for (int i = 0; i < NR; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            rrw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) ra = 16'($urandom_range(0, 16'h0080));
            else                           ra = 16'hFFE0 + 16'($urandom_range(0, 31));
            rd = 16'($urandom);
            set_req(i, rrw, ra, rd);
          end
        end
      end
      prev_valid = req_valid;
      tick();
    end
    chk("rnd drained", eq.size(), 0);
    chk("rnd enough grants", grants >= 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
